// File: rtl/main_mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: default geometry, owner encoding
// and the round-robin pointer helper.
package main_mem_arbiter_pkg;

    localparam int DEF_NUM_CORES             = 3;
    localparam int DEF_MAIN_MEMORY_ADDR_BITS = 8;
    localparam int DATA_BITS                 = 32;

    // Who drove the memory port in the previous cycle; core k encodes as OWNER_CORE0 + k.
    typedef enum logic [3:0] {
        OWNER_NONE  = 4'd0,
        OWNER_HOST  = 4'd1,
        OWNER_CORE0 = 4'd2
    } owner_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/main_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at WIDTH-1.
module main_mem_arbiter_rr_arbiter #(
    parameter int WIDTH    = 3,
    parameter int IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]    req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [WIDTH-1:0]    grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_valid
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = 0; off < WIDTH; off++) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = IDX_BITS'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares one single-port synchronous main memory between the per-core memory
// controllers (round-robin) and a Wishbone slave port (throttled priority).
module main_mem_arbiter
    import main_mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES             = DEF_NUM_CORES,
    parameter int MAIN_MEMORY_ADDR_BITS = DEF_MAIN_MEMORY_ADDR_BITS
) (
    input  logic                                       clk,
    input  logic                                       rst,

    input  logic [NUM_CORES-1:0]                       core_req,
    input  logic [NUM_CORES-1:0]                       core_we,
    input  logic [NUM_CORES*MAIN_MEMORY_ADDR_BITS-1:0] core_addr,
    input  logic [NUM_CORES*32-1:0]                    core_din,
    output logic [NUM_CORES-1:0]                       core_grant,
    output logic [31:0]                                core_dout,

    input  logic                                       wb_cyc_i,
    input  logic                                       wb_stb_i,
    input  logic                                       wb_we_i,
    input  logic [MAIN_MEMORY_ADDR_BITS-1:0]           wb_adr_i,
    input  logic [31:0]                                wb_dat_i,
    output logic                                       wb_ack_o,
    output logic [31:0]                                wb_dat_o,

    output logic                                       mem_en,
    output logic                                       mem_we,
    output logic [MAIN_MEMORY_ADDR_BITS-1:0]           mem_addr,
    output logic [31:0]                                mem_din,
    input  logic [31:0]                                mem_dout
);

    localparam int PTR_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AB       = MAIN_MEMORY_ADDR_BITS;

    logic [PTR_BITS-1:0]  rr_ptr;
    logic                 wb_block;
    owner_t               last_owner;

    logic [NUM_CORES-1:0] arb_grant;
    logic [PTR_BITS-1:0]  arb_idx;
    logic                 arb_valid;
    logic                 wb_win;
    logic                 core_win;

    main_mem_arbiter_rr_arbiter #(
        .WIDTH    (NUM_CORES),
        .IDX_BITS (PTR_BITS)
    ) u_rr (
        .req         (core_req),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // An un-acked strobe wins unless it was just served and cores are still waiting.
    assign wb_win   = !rst && wb_cyc_i && wb_stb_i && !wb_ack_o && !(wb_block && |core_req);
    assign core_win = !rst && !wb_win && arb_valid;

    always_comb begin
        core_grant = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        if (wb_win) begin
            mem_en   = 1'b1;
            mem_we   = wb_we_i;
            mem_addr = wb_adr_i;
            mem_din  = wb_dat_i;
        end else if (core_win) begin
            core_grant = arb_grant;
            mem_en     = 1'b1;
            mem_we     = core_we[arb_idx];
            mem_addr   = core_addr[int'(arb_idx)*AB +: AB];
            mem_din    = core_din[int'(arb_idx)*32 +: 32];
        end
    end

    assign core_dout = mem_dout;
    // Host read data is only meaningful in the cycle after a host access, i.e. while ack is high.
    assign wb_dat_o  = (last_owner == OWNER_HOST) ? mem_dout : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            wb_ack_o   <= 1'b0;
            wb_block   <= 1'b0;
            last_owner <= OWNER_NONE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wb_ack_o <= wb_win;
            if (wb_win) begin
                wb_block   <= 1'b1;
                last_owner <= OWNER_HOST;
            end else if (core_win) begin
                wb_block   <= 1'b0;
                rr_ptr     <= PTR_BITS'(rr_next(int'(arb_idx), NUM_CORES));
                last_owner <= owner_t'(4'(OWNER_CORE0) + 4'(arb_idx));
            end else begin
                if (core_req == '0) begin
                    wb_block <= 1'b0;
                end
                last_owner <= OWNER_NONE;
            end
        end
    end

endmodule
